// File: rtl/inter_switch_nxm.sv
// N-input, M-output streaming switch: one configured source is routed through a
// small FIFO to any subset of outputs for a programmed number of beats.
module inter_switch_nxm #(
   parameter int DATA_W = 1536,
   parameter int N_IN   = 5,
   parameter int N_OUT  = 8,
   parameter int DEPTH  = 4,
   parameter int SEL_W  = $clog2(N_IN)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [SEL_W-1:0]         cfg_in_sel,
   input  logic [N_OUT-1:0]         cfg_out_mask,
   input  logic [15:0]              cfg_len,
   input  logic [N_IN*DATA_W-1:0]   s_tdata,
   input  logic [N_IN-1:0]          s_tvalid,
   output logic [N_IN-1:0]          s_tready,
   output logic [DATA_W-1:0]        m_tdata,
   output logic                     m_tlast,
   output logic [N_OUT-1:0]         m_tvalid,
   input  logic [N_OUT-1:0]         m_tready,
   output logic                     done,
   output logic                     err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN
   } state_t;

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [N_OUT-1:0]   mask_q, mask_d;
   logic [15:0]        len_q, len_d;
   logic [15:0]        in_cnt_q, in_cnt_d;
   logic [15:0]        out_cnt_q, out_cnt_d;
   logic [N_OUT-1:0]   sent_q, sent_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic [DATA_W-1:0]  fifo_mem_q [DEPTH];
   logic [DATA_W-1:0]  s_data_arr [N_IN];

   logic               fifo_nempty;
   logic               in_open;
   logic               push;
   logic               pop;
   logic [N_OUT-1:0]   accept;
   logic [N_OUT-1:0]   taken;

   genvar gi;
   generate
      for (gi = 0; gi < N_IN; gi++) begin : g_in
         assign s_data_arr[gi] = s_tdata[gi*DATA_W +: DATA_W];
         assign s_tready[gi]   = in_open & (sel_q == SEL_W'(gi));
      end
   endgenerate

   assign fifo_nempty = (count_q != '0);
   assign in_open     = (state_q == ST_RUN) && (count_q < CNT_W'(DEPTH)) && (in_cnt_q < len_q);
   assign push        = |(s_tready & s_tvalid);

   // An output that already took the head beat keeps it in sent until every
   // selected output has it; only then does the head leave the FIFO.
   assign m_tvalid = fifo_nempty ? (mask_q & ~sent_q) : '0;
   assign accept   = m_tvalid & m_tready;
   assign taken    = sent_q | accept;
   assign pop      = fifo_nempty && ((mask_q & ~taken) == '0);

   assign m_tdata   = fifo_nempty ? fifo_mem_q[rd_ptr_q] : '0;
   assign m_tlast   = fifo_nempty && (out_cnt_q == len_q - 16'd1);
   assign cfg_ready = (state_q == ST_IDLE);
   assign done      = done_q;
   assign err       = err_q;

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      mask_d    = mask_q;
      len_d     = len_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      sent_d    = sent_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      done_d    = 1'b0;
      err_d     = 1'b0;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
         in_cnt_d = in_cnt_q + 16'd1;
      end
      if (pop) begin
         rd_ptr_d  = rd_ptr_q + PTR_W'(1);
         out_cnt_d = out_cnt_q + 16'd1;
         sent_d    = '0;
      end else if (fifo_nempty) begin
         sent_d = taken;
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      unique case (state_q)
         ST_IDLE: begin
            if (cfg_valid) begin
               if ((32'(cfg_in_sel) >= N_IN) || (cfg_len == 16'd0)) begin
                  err_d = 1'b1;
               end else begin
                  sel_d     = cfg_in_sel;
                  mask_d    = cfg_out_mask;
                  len_d     = cfg_len;
                  in_cnt_d  = '0;
                  out_cnt_d = '0;
                  sent_d    = '0;
                  state_d   = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (push && (in_cnt_q + 16'd1 == len_q)) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (pop && (out_cnt_q + 16'd1 == len_q)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         sel_q     <= '0;
         mask_q    <= '0;
         len_q     <= '0;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         sent_q    <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         mask_q    <= mask_d;
         len_q     <= len_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         sent_q    <= sent_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // Storage is not reset; m_tdata is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= s_data_arr[sel_q];
      end
   end

endmodule
